// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared codes, states and request checking for mem_access_unit
package mem_access_unit_pkg;

   localparam int DEF_MEM_ADDR_W = 16;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Size/alignment legality only; the address range check depends on the top's parameter.
   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lsb);
      logic bad;
      bad = 1'b0;
      case (f3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = lsb[0];
         F3_W:        bad = |lsb;
         default:     bad = 1'b1;
      endcase
      if (we && f3[2]) bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU request and data-memory signals of mem_access_unit
interface mem_access_unit_if;

   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_addr;
   logic [31:0] m_din;
   logic [31:0] m_dout;

   modport master (
      output req, we, funct3, addr, wdata, m_dout,
      input  busy, done, rdata, err, m_read, m_write, m_addr, m_din
   );

   modport slave (
      input  req, we, funct3, addr, wdata, m_dout,
      output busy, done, rdata, err, m_read, m_write, m_addr, m_din
   );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - load lane extract/extend and sub-word store merge
module mem_access_unit_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  byte_sel,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b    = word[{byte_sel, 3'b000} +: 8];
      lane_h    = byte_sel[1] ? word[31:16] : word[15:0];
      load_data = word;
      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   load_data = {24'd0, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   load_data = {16'd0, lane_h};
         default: load_data = word;
      endcase
   end

   // Sub-word stores keep every other lane of the fetched word untouched.
   always_comb begin
      store_word = wdata;
      case (funct3[1:0])
         2'b00: begin
            store_word = word;
            store_word[{byte_sel, 3'b000} +: 8] = wdata[7:0];
         end
         2'b01: begin
            store_word = word;
            if (byte_sel[1]) store_word[31:16] = wdata[15:0];
            else             store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator onto a word-only data memory
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_ADDR_W = DEF_MEM_ADDR_W
)(
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);

   state_t      state_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_err;
   logic [31:0] align_word;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign req_err = access_err(bus.we, bus.funct3, bus.addr[1:0])
                  | ((bus.addr >> MEM_ADDR_W) != 32'd0);

   // Loads extract from the live memory word in RD; merges use the word captured there.
   assign align_word = (state_q == S_RD) ? bus.m_dout : word_q;

   mem_access_unit_lane_align u_lane_align (
      .word       (align_word),
      .wdata      (wdata_q),
      .byte_sel   (addr_q[1:0]),
      .funct3     (f3_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  we_q    <= bus.we;
                  f3_q    <= bus.funct3;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  err_q   <= req_err;
                  if (req_err)                  state_q <= S_DONE;
                  else if (!bus.we)             state_q <= S_RD;
                  else if (bus.funct3 == F3_W)  state_q <= S_WR;
                  else                          state_q <= S_RD;
               end
            end
            S_RD: begin
               word_q <= bus.m_dout;
               if (!we_q) rdata_q <= load_data;
               state_q <= we_q ? S_WR : S_DONE;
            end
            S_WR: begin
               state_q <= S_DONE;
            end
            S_DONE: begin
               err_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.err     = err_q;
   assign bus.rdata   = rdata_q;
   // Gated by rst so an abandoned store cannot land on the reset edge.
   assign bus.m_read  = (state_q == S_RD) & ~rst;
   assign bus.m_write = (state_q == S_WR) & ~rst;
   assign bus.m_addr  = {addr_q[31:2], 2'b00};
   assign bus.m_din   = store_word;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a word memory model
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_access_unit_if bus_i ();

   mem_access_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
   );

   logic [31:0] mem [0:16383];
   logic        poke_en;
   logic [31:0] poke_addr;
   logic [31:0] poke_data;
   int          rd_cnt  = 0;
   int          wr_cnt  = 0;
   logic        overlap = 1'b0;

   int total = 0;
   int bad   = 0;

   always_comb bus_i.m_dout = mem[bus_i.m_addr[15:2]];

   always @(posedge clk) begin
      if (poke_en)              mem[poke_addr[15:2]] <= poke_data;
      else if (bus_i.m_write)   mem[bus_i.m_addr[15:2]] <= bus_i.m_din;
      if (bus_i.m_read)                  rd_cnt  <= rd_cnt + 1;
      if (bus_i.m_write)                 wr_cnt  <= wr_cnt + 1;
      if (bus_i.m_read && bus_i.m_write) overlap <= 1'b1;
   end

   function automatic logic [31:0] peek(input logic [31:0] a);
      return mem[a[15:2]];
   endfunction

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Issues one request and waits for done; lat counts cycles after the accepting edge.
   task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int nrd, output int nwr);
      int rd0, wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      bus_i.req = 1'b1; bus_i.we = w; bus_i.funct3 = f3; bus_i.addr = a; bus_i.wdata = d;
      @(posedge clk); #1;
      bus_i.req = 1'b0;
      lat = 1;
      while (!bus_i.done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus_i.done) lat = 99;
      nrd = rd_cnt - rd0;
      nwr = wr_cnt - wr0;
   endtask

   task automatic idle_cycle;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; poke_en = 1'b0;
      bus_i.req = 1'b0; bus_i.we = 1'b0; bus_i.funct3 = 3'b000; bus_i.addr = 32'd0; bus_i.wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus_i.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", bus_i.busy); end
      total++; if (bus_i.done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", bus_i.done); end
      total++; if (bus_i.err !== 1'b0)      begin bad++; $display("FAIL reset_err: got %b want 0", bus_i.err); end
      total++; if (bus_i.m_read !== 1'b0)   begin bad++; $display("FAIL reset_m_read: got %b want 0", bus_i.m_read); end
      total++; if (bus_i.m_write !== 1'b0)  begin bad++; $display("FAIL reset_m_write: got %b want 0", bus_i.m_write); end
      total++; if (bus_i.rdata !== 32'd0)   begin bad++; $display("FAIL reset_rdata: got %h want 0", bus_i.rdata); end
      total++; if (bus_i.m_addr !== 32'd0)  begin bad++; $display("FAIL reset_m_addr: got %h want 0", bus_i.m_addr); end
      total++; if (bus_i.m_din !== 32'd0)   begin bad++; $display("FAIL reset_m_din: got %h want 0", bus_i.m_din); end
      rst = 1'b0;
      idle_cycle();
      total++; if (bus_i.busy !== 1'b0)     begin bad++; $display("FAIL post_reset_busy: got %b want 0", bus_i.busy); end
   endtask

   task automatic test_sw_lw;
      int lat, nrd, nwr;
      do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, nrd, nwr);
      total++; if (lat !== 2)               begin bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
      total++; if (bus_i.err !== 1'b0)      begin bad++; $display("FAIL sw_err: got %b want 0", bus_i.err); end
      total++; if (nrd !== 0 || nwr !== 1)  begin bad++; $display("FAIL sw_accesses: got rd=%0d wr=%0d want rd=0 wr=1", nrd, nwr); end
      idle_cycle();
      total++; if (peek(32'h10) !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem: got %h want deadbeef", peek(32'h10)); end
      do_access(1'b0, 3'b010, 32'h10, 32'd0, lat, nrd, nwr);
      total++; if (lat !== 2)               begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
      total++; if (bus_i.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", bus_i.rdata); end
      total++; if (bus_i.err !== 1'b0)      begin bad++; $display("FAIL lw_err: got %b want 0", bus_i.err); end
      total++; if (nrd !== 1 || nwr !== 0)  begin bad++; $display("FAIL lw_accesses: got rd=%0d wr=%0d want rd=1 wr=0", nrd, nwr); end
      idle_cycle();
   endtask

   task automatic test_sb_rmw;
      int lat, nrd, nwr;
      poke(32'h20, 32'h11223344);
      do_access(1'b1, 3'b000, 32'h21, 32'h000000AA, lat, nrd, nwr);
      total++; if (lat !== 3)               begin bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
      total++; if (nrd !== 1 || nwr !== 1)  begin bad++; $display("FAIL sb_accesses: got rd=%0d wr=%0d want rd=1 wr=1", nrd, nwr); end
      total++; if (bus_i.err !== 1'b0)      begin bad++; $display("FAIL sb_err: got %b want 0", bus_i.err); end
      idle_cycle();
      total++; if (peek(32'h20) !== 32'h1122AA44) begin bad++; $display("FAIL sb_mem: got %h want 1122aa44", peek(32'h20)); end
   endtask

   task automatic test_load_ext;
      int lat, nrd, nwr;
      logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] adrs [4] = '{32'h30, 32'h30, 32'h32, 32'h32};
      logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'h00008000};
      poke(32'h30, 32'h8000F0FF);
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, f3s[i], adrs[i], 32'd0, lat, nrd, nwr);
         total++; if (bus_i.rdata !== exps[i]) begin bad++; $display("FAIL load_ext_%0d: got %h want %h", i, bus_i.rdata, exps[i]); end
         total++; if (lat !== 2)               begin bad++; $display("FAIL load_ext_lat_%0d: got %0d want 2", i, lat); end
         idle_cycle();
      end
   endtask

   task automatic test_errors;
      int lat, nrd, nwr;
      logic        ws   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
      logic [31:0] adrs [5] = '{32'h13, 32'h31, 32'h10000, 32'h10, 32'h30};
      for (int i = 0; i < 5; i++) begin
         do_access(ws[i], f3s[i], adrs[i], 32'h5A5A5A5A, lat, nrd, nwr);
         total++; if (lat !== 1)               begin bad++; $display("FAIL err_lat_%0d: got %0d want 1", i, lat); end
         total++; if (bus_i.err !== 1'b1)      begin bad++; $display("FAIL err_flag_%0d: got %b want 1", i, bus_i.err); end
         total++; if (nrd !== 0 || nwr !== 0)  begin bad++; $display("FAIL err_access_%0d: got rd=%0d wr=%0d want 0 0", i, nrd, nwr); end
         total++; if (bus_i.rdata !== 32'h00008000) begin bad++; $display("FAIL err_rdata_%0d: got %h want 00008000", i, bus_i.rdata); end
         idle_cycle();
         total++; if (bus_i.err !== 1'b0)      begin bad++; $display("FAIL err_clear_%0d: got %b want 0", i, bus_i.err); end
      end
      total++; if (peek(32'h10) !== 32'hDEADBEEF) begin bad++; $display("FAIL err_mem10: got %h want deadbeef", peek(32'h10)); end
      total++; if (peek(32'h30) !== 32'h8000F0FF) begin bad++; $display("FAIL err_mem30: got %h want 8000f0ff", peek(32'h30)); end
   endtask

   task automatic test_rst_abort;
      int  wr0;
      logic saw_done;
      poke(32'h40, 32'h12345678);
      wr0 = wr_cnt;
      bus_i.req = 1'b1; bus_i.we = 1'b1; bus_i.funct3 = 3'b001; bus_i.addr = 32'h40; bus_i.wdata = 32'h00005555;
      @(posedge clk); #1;
      bus_i.req = 1'b0;
      @(posedge clk); #1;
      total++; if (bus_i.m_write !== 1'b1)  begin bad++; $display("FAIL abort_in_wr: got m_write=%b want 1", bus_i.m_write); end
      rst = 1'b1;
      #1;
      total++; if (bus_i.m_write !== 1'b0)  begin bad++; $display("FAIL abort_gate: got m_write=%b want 0", bus_i.m_write); end
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (bus_i.busy !== 1'b0)     begin bad++; $display("FAIL abort_idle: got busy=%b want 0", bus_i.busy); end
      saw_done = bus_i.done;
      repeat (3) begin
         @(posedge clk); #1;
         saw_done = saw_done | bus_i.done;
      end
      total++; if (saw_done !== 1'b0)       begin bad++; $display("FAIL abort_done: got %b want 0", saw_done); end
      total++; if (wr_cnt - wr0 !== 0)      begin bad++; $display("FAIL abort_writes: got %0d want 0", wr_cnt - wr0); end
      total++; if (peek(32'h40) !== 32'h12345678) begin bad++; $display("FAIL abort_mem: got %h want 12345678", peek(32'h40)); end
   endtask

   task automatic test_back_to_back;
      int rd0, lat, nrd, nwr;
      poke(32'h50, 32'hCAFEF00D);
      rd0 = rd_cnt;
      bus_i.req = 1'b1; bus_i.we = 1'b0; bus_i.funct3 = 3'b010; bus_i.addr = 32'h50; bus_i.wdata = 32'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (bus_i.done !== 1'b1)     begin bad++; $display("FAIL held_done: got %b want 1", bus_i.done); end
      total++; if (bus_i.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL held_rdata: got %h want cafef00d", bus_i.rdata); end
      @(posedge clk); #1;
      total++; if (bus_i.busy !== 1'b0)     begin bad++; $display("FAIL held_idle: got busy=%b want 0", bus_i.busy); end
      total++; if (rd_cnt - rd0 !== 1)      begin bad++; $display("FAIL held_single: got reads=%0d want 1", rd_cnt - rd0); end
      @(posedge clk); #1;
      bus_i.req = 1'b0;
      total++; if (bus_i.busy !== 1'b1)     begin bad++; $display("FAIL held_second: got busy=%b want 1", bus_i.busy); end
      @(posedge clk); #1;
      total++; if (bus_i.done !== 1'b1)     begin bad++; $display("FAIL held_second_done: got %b want 1", bus_i.done); end
      idle_cycle();
      total++; if (rd_cnt - rd0 !== 2)      begin bad++; $display("FAIL held_reads: got %0d want 2", rd_cnt - rd0); end
      do_access(1'b1, 3'b001, 32'h52, 32'h1234BEEF, lat, nrd, nwr);
      total++; if (lat !== 3)               begin bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
      idle_cycle();
      total++; if (peek(32'h50) !== 32'hBEEFF00D) begin bad++; $display("FAIL sh_mem: got %h want beeff00d", peek(32'h50)); end
      do_access(1'b0, 3'b101, 32'h52, 32'd0, lat, nrd, nwr);
      total++; if (bus_i.rdata !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_rdata: got %h want 0000beef", bus_i.rdata); end
      idle_cycle();
      total++; if (overlap !== 1'b0)        begin bad++; $display("FAIL rd_wr_overlap: got %b want 0", overlap); end
   endtask

   initial begin
      test_reset();
      test_sw_lw();
      test_sb_rmw();
      test_load_ext();
      test_errors();
      test_rst_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
